// File: rtl/spi_req_arbiter_if.sv
// Client-side request/grant bundle plus the clk-domain spi_master hookup
// that the round-robin arbiter sits between.
interface spi_req_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;
  logic [DATA_WIDTH-1:0]         rx_data;
  logic                          busy;
  logic                          m_tx_start;
  logic [DATA_WIDTH-1:0]         m_tx_data;
  logic                          m_cs_n;
  logic [DATA_WIDTH-1:0]         m_rx_data;

  // Arbiter side.
  modport slave (
    input  req, req_data, m_cs_n, m_rx_data,
    output gnt, done, err, rx_data, busy, m_tx_start, m_tx_data
  );

  // Clients and spi_master side.
  modport master (
    output req, req_data, m_cs_n, m_rx_data,
    input  gnt, done, err, rx_data, busy, m_tx_start, m_tx_data
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one spi_master among NUM_REQ clients; completion is
// the cs_n low-then-high envelope, with a per-wait-state timeout abort.
module spi_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  spi_req_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_ASSERT, WAIT_DEASSERT} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [IDX_W:0]        sum;
  logic [IDX_W-1:0]      pick;
  logic                  pick_vld;
  logic [IDX_W-1:0]      next_ptr;
  logic                  timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_word[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from highest offset down so the lowest offset from ptr wins last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (bus.req[sum[IDX_W-1:0]]) begin
        pick     = sum[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign next_ptr    = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    busy_d   = busy_q;
    start_d  = 1'b0;
    tx_d     = tx_q;
    rx_d     = rx_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          winner_d    = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
          tx_d        = req_word[pick];
          state_d     = START;
        end
      end
      START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ASSERT;
      end
      WAIT_ASSERT, WAIT_DEASSERT: begin
        if ((state_q == WAIT_ASSERT) && !bus.m_cs_n) begin
          cnt_d   = '0;
          state_d = WAIT_DEASSERT;
        end else if ((state_q == WAIT_DEASSERT) && bus.m_cs_n) begin
          rx_d             = bus.m_rx_data;
          done_d[winner_q] = 1'b1;
          gnt_d            = '0;
          busy_d           = 1'b0;
          ptr_d            = next_ptr;
          cnt_d            = '0;
          state_d          = IDLE;
        end else if (timeout_hit) begin
          err_d[winner_q] = 1'b1;
          gnt_d           = '0;
          busy_d          = 1'b0;
          ptr_d           = next_ptr;
          cnt_d           = '0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.rx_data    = rx_q;
  assign bus.m_tx_start = start_q;
  assign bus.m_tx_data  = tx_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a vector table of grant/data/echo
// expectations plus hand-written timeout, reset and req-drop sequences.
module tb_spi_req_arbiter;
  localparam logic [31:0] WORDS = 32'h44A5_2211;
  localparam logic [7:0]  ECHO  = 8'h99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic master_en = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spi_req_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  spi_req_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // spi_master stand-in: cs_n low 2 cycles after tx_start, returns tx ^ ECHO.
  initial begin : master_model
    logic [7:0] cap;
    bus.m_cs_n    = 1'b1;
    bus.m_rx_data = '0;
    forever begin
      @(negedge clk);
      if (bus.m_tx_start && master_en) begin
        cap = bus.m_tx_data;
        repeat (2) @(negedge clk);
        bus.m_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.m_rx_data = cap ^ ECHO;
        bus.m_cs_n    = 1'b1;
      end
    end
  end

  // Cycle-by-cycle exclusivity and single-cycle pulse checks.
  initial begin : monitor
    logic [3:0] done_prev, err_prev;
    done_prev = '0;
    err_prev  = '0;
    forever begin
      @(negedge clk);
      check("excl_done_gnt", 32'(bus.done & bus.gnt), 32'h0);
      check("excl_err_gnt",  32'(bus.err & bus.gnt), 32'h0);
      check("excl_done_err", 32'((|bus.done) & (|bus.err)), 32'h0);
      check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
      check("done_width", 32'(bus.done & done_prev), 32'h0);
      check("err_width",  32'(bus.err & err_prev), 32'h0);
      done_prev = bus.done;
      err_prev  = bus.err;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] tx;
    logic [7:0] rx;
  } vec_t;

  // Called at a negedge while the arbiter is idle; runs one full transaction.
  task automatic run_txn(input int id, input vec_t v);
    int n;
    string tag;
    tag = $sformatf("v%0d", id);
    bus.req      = v.req;
    bus.req_data = WORDS;
    n = 0;
    while (bus.gnt == 0 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd1);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(v.gnt));
    check({tag, "_busy"}, 32'(bus.busy), 32'h1);
    check({tag, "_start_pre"}, 32'(bus.m_tx_start), 32'h0);
    @(negedge clk);
    check({tag, "_start"}, 32'(bus.m_tx_start), 32'h1);
    check({tag, "_tx"}, 32'(bus.m_tx_data), 32'(v.tx));
    bus.req_data = ~WORDS;
    @(negedge clk);
    check({tag, "_start_post"}, 32'(bus.m_tx_start), 32'h0);
    n = 0;
    while (bus.done == 0 && bus.err == 0 && n < 100) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(bus.done), 32'(v.gnt));
    check({tag, "_err"}, 32'(bus.err), 32'h0);
    check({tag, "_rx"}, 32'(bus.rx_data), 32'(v.rx));
    check({tag, "_tx_stable"}, 32'(bus.m_tx_data), 32'(v.tx));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'h0);
    check({tag, "_gnt_end"}, 32'(bus.gnt), 32'h0);
    bus.req_data = WORDS;
    $display("txn %s req=%b gnt=%b tx=%h rx=%h", tag, v.req, v.gnt, v.tx, bus.rx_data);
  endtask

  vec_t vecs [9];

  initial begin : main
    int n, hits;
    vec_t follow;
    vecs[0] = '{req: 4'b1111, gnt: 4'b0001, tx: 8'h11, rx: 8'h88};
    vecs[1] = '{req: 4'b1111, gnt: 4'b0010, tx: 8'h22, rx: 8'hBB};
    vecs[2] = '{req: 4'b1111, gnt: 4'b0100, tx: 8'hA5, rx: 8'h3C};
    vecs[3] = '{req: 4'b1111, gnt: 4'b1000, tx: 8'h44, rx: 8'hDD};
    vecs[4] = '{req: 4'b1111, gnt: 4'b0001, tx: 8'h11, rx: 8'h88};
    vecs[5] = '{req: 4'b1010, gnt: 4'b0010, tx: 8'h22, rx: 8'hBB};
    vecs[6] = '{req: 4'b1010, gnt: 4'b1000, tx: 8'h44, rx: 8'hDD};
    vecs[7] = '{req: 4'b1010, gnt: 4'b0010, tx: 8'h22, rx: 8'hBB};
    vecs[8] = '{req: 4'b0100, gnt: 4'b0100, tx: 8'hA5, rx: 8'h3C};

    bus.req      = '0;
    bus.req_data = WORDS;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_start", 32'(bus.m_tx_start), 32'h0);
    check("rst_tx", 32'(bus.m_tx_data), 32'h0);
    check("rst_rx", 32'(bus.rx_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Timeout: master never drops cs_n; pointer is 3 so req[3] wins.
    master_en = 1'b0;
    bus.req   = 4'b1001;
    n = 0;
    while (bus.gnt == 0 && n < 20) begin @(negedge clk); n++; end
    check("to_gnt", 32'(bus.gnt), 32'h8);
    @(negedge clk);
    check("to_start", 32'(bus.m_tx_start), 32'h1);
    n = 0;
    hits = 0;
    while (bus.err == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.done != 0) hits++;
    end
    check("to_delay", 32'(n), 32'd16);
    check("to_err", 32'(bus.err), 32'h8);
    check("to_no_done", 32'(hits), 32'h0);
    check("to_rx_held", 32'(bus.rx_data), 32'h3C);
    check("to_busy", 32'(bus.busy), 32'h0);
    $display("txn timeout err=%b after %0d cycles", bus.err, n);
    master_en = 1'b1;
    follow = '{req: 4'b1001, gnt: 4'b0001, tx: 8'h11, rx: 8'h88};
    run_txn(9, follow);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset while in WAIT_DEASSERT; pointer is 1 here so req[2] wins.
    bus.req = 4'b0100;
    n = 0;
    while (bus.gnt == 0 && n < 20) begin @(negedge clk); n++; end
    check("rs_gnt", 32'(bus.gnt), 32'h4);
    n = 0;
    while (bus.m_cs_n && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_gnt0", 32'(bus.gnt), 32'h0);
    check("rs_busy", 32'(bus.busy), 32'h0);
    check("rs_rx", 32'(bus.rx_data), 32'h0);
    check("rs_tx", 32'(bus.m_tx_data), 32'h0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done != 0 || bus.err != 0) hits++;
      @(negedge clk);
    end
    check("rs_no_pulse", 32'(hits), 32'h0);
    $display("txn reset_mid gnt=%b busy=%b rx=%h", bus.gnt, bus.busy, bus.rx_data);
    follow = '{req: 4'b0101, gnt: 4'b0001, tx: 8'h11, rx: 8'h88};
    run_txn(10, follow);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // req[0] dropped two cycles after grant: must still complete, no re-grant.
    bus.req = 4'b0001;
    n = 0;
    while (bus.gnt == 0 && n < 20) begin @(negedge clk); n++; end
    check("dr_gnt", 32'(bus.gnt), 32'h1);
    repeat (2) @(negedge clk);
    bus.req = '0;
    n = 0;
    while (bus.done == 0 && bus.err == 0 && n < 100) begin @(negedge clk); n++; end
    check("dr_done", 32'(bus.done), 32'h1);
    check("dr_rx", 32'(bus.rx_data), 32'h88);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.gnt != 0) hits++;
    end
    check("dr_no_regnt", 32'(hits), 32'h0);
    $display("txn req_drop done=1 rx=%h regrants=%0d", bus.rx_data, hits);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one spi_master instance among NUM_REQ client requesters using round-robin arbitration.
- For each granted requester it latches the transmit word, pulses the master's tx_start, and tracks the master's cs_n low-then-high envelope to detect completion.
- On completion it returns the received word with a per-requester done pulse.
- A timeout guard covers a master that never starts or never finishes.
- Sits between client logic and the spi_master clk-domain ports inside the SPI subsystem top.

Parameters:
DATA_WIDTH, 8, SPI word width; must match the spi_master instance.
NUM_REQ, 4, number of requesters (2..16).
TIMEOUT, 1024, max clk cycles allowed in each wait state before abort.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
req  input  NUM_REQ  per-requester transaction request, level.
req_data  input  NUM_REQ*DATA_WIDTH  per-requester TX word; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
err  output  NUM_REQ  one-cycle timeout-abort pulse to the owning requester.
rx_data  output  DATA_WIDTH  last received word; valid when any done bit is high; held until the next completion.
busy  output  1  high from grant until completion or abort.
m_tx_start  output  1  to spi_master tx_start.
m_tx_data  output  DATA_WIDTH  to spi_master TX_DATA.
m_cs_n  input  1  from spi_master cs_n.
m_rx_data  input  DATA_WIDTH  from spi_master RX_DATA.

Behaviour:
- Reset values:
  - gnt, done, err, busy, m_tx_start = 0.
  - rx_data, m_tx_data = 0.
  - Round-robin pointer = 0; state = IDLE; timeout counter = 0.
- States: IDLE, START, WAIT_ASSERT, WAIT_DEASSERT.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, select the first set bit at index >= pointer, wrapping modulo NUM_REQ.
  - Next edge: gnt = one-hot of the winner, busy = 1, m_tx_data = winner's req_data slice, go to START.
  - Latency from req sampled high to gnt high: 1 cycle.
- START:
  - m_tx_start = 1 for exactly one cycle, in the cycle after gnt rises.
  - Clear the counter; go to WAIT_ASSERT.
- WAIT_ASSERT:
  - On m_cs_n == 0: clear the counter, go to WAIT_DEASSERT.
  - Otherwise increment the counter.
- WAIT_DEASSERT:
  - On m_cs_n == 1: rx_data = m_rx_data and done[winner] = 1 on the same edge; gnt = 0, busy = 0; pointer = (winner+1) mod NUM_REQ; go to IDLE.
  - Otherwise increment the counter.
- Timeout (either wait state):
  - Triggers when the counter reaches TIMEOUT-1 with the exit condition still false.
  - Next edge: err[winner] = 1 for one cycle, gnt = 0, busy = 0, rx_data unchanged; pointer advances as on completion; go to IDLE.
- Counter width: clog2(TIMEOUT+1); it never wraps.
- Stability while gnt is high:
  - m_tx_data is stable.
  - Changes on req or req_data are ignored.
  - Dropping req mid-transaction does not abort; done still pulses.
- Back-to-back: at least one IDLE cycle between completion and the next gnt. A requester holding req after its done re-competes at lowest priority.
- Simultaneous requests: exactly one grant; the others stay pending with no loss.
- done, err and gnt are never high in the same cycle for the same index. done and err never assert together.
- Reset mid-operation: all outputs return to reset values on the next edge. Any master transfer in flight is abandoned without a done or err pulse.

Test Plan:
1. Only req[2] high, data 0xA5; master model echoes 0x3C.
   -> gnt = 0100 one cycle later, one m_tx_start pulse, done[2] pulse when cs_n rises, rx_data = 0x3C, busy low afterwards.
2. req = 1111 held continuously.
   -> grants in order 0,1,2,3,0; each m_tx_data matches its slice; exactly one done per grant; at least one idle cycle between grants.
3. After granting req[1] with req[1] and req[3] held.
   -> next grant is 3, then 1 (pointer rotation verified).
4. m_cs_n stuck high, TIMEOUT = 16.
   -> err[winner] pulses 16 cycles after START, no done, rx_data unchanged, next requester granted.
5. rst asserted for one cycle during WAIT_DEASSERT.
   -> next edge: gnt = 0, busy = 0, rx_data = 0, pointer = 0; no done or err; a following req[0] is granted first.
6. req[0] dropped two cycles after gnt.
   -> transaction completes, done[0] pulses, no re-grant to 0.
